// File: rtl/tlb_pkg.sv
// Shared types, entry field positions and parity helper for the TLB RAM sequencer.
package tlb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWs,
    StWp,
    StWh,
    StSw
  } tlb_state_e;

  localparam int unsigned DataW    = 20;
  localparam int unsigned AddrW    = 8;
  // RAM data bit 0 carries entry bit D[4]
  localparam int unsigned DLsb     = 4;
  localparam int unsigned TagWDef  = 5;

  localparam int unsigned VALID_BIT = 23;
  localparam int unsigned TAG_HI    = 22;
  localparam int unsigned TAG_LO    = TAG_HI - TagWDef + 1;

  localparam int unsigned G0Hi = 11;
  localparam int unsigned G0Lo = 4;
  localparam int unsigned G1Hi = 19;
  localparam int unsigned G1Lo = 12;
  localparam int unsigned G2Hi = 23;
  localparam int unsigned G2Lo = 20;

  function automatic logic [2:0] tlb_parity(input logic [DataW-1:0] d, input logic odd);
    logic [2:0] p;
    p[0] = (^d[G0Hi-DLsb:G0Lo-DLsb]) ^ odd;
    p[1] = (^d[G1Hi-DLsb:G1Lo-DLsb]) ^ odd;
    p[2] = (^d[G2Hi-DLsb:G2Lo-DLsb]) ^ odd;
    return p;
  endfunction

endpackage

// File: rtl/tlb_ctl_par3.sv
// Combinational three-group parity generator over a 20-bit TLB entry (D[23:4]).
module tlb_par3
  import tlb_pkg::*;
#(
  parameter bit PAR_ODD = 1'b1
) (
  input  logic [DataW-1:0] d_i,
  output logic [2:0]       p_o
);

  always_comb begin
    p_o = tlb_parity(d_i, PAR_ODD);
  end

endmodule

// File: rtl/tlb_ctl.sv
// Sequencer for the 256-entry asynchronous TLB RAM: lookup, fill and invalidate-all.
// Optional macro TLB_SCRUB_EN: a lookup with a parity error zeroes the corrupt entry.
module tlb_ctl
  import tlb_pkg::*;
#(
  parameter int unsigned TAG_W   = TagWDef,
  parameter bit          PAR_ODD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_req,
  input  logic [7:0]       lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  input  logic             fl_req,
  input  logic [7:0]       fl_idx,
  input  logic [19:0]      fl_data,
  input  logic             inv_req,
  output logic [7:0]       ram_a,
  output logic [19:0]      ram_d,
  output logic [2:0]       ram_dp,
  output logic             ram_nwe,
  input  logic [19:0]      ram_q,
  input  logic [2:0]       ram_qp,
  output logic             busy,
  output logic             lk_done,
  output logic             lk_hit,
  output logic [19:0]      lk_data,
  output logic             perr
);

  tlb_state_e state_q, state_d;

  logic [AddrW-1:0] ram_a_q, ram_a_d;
  logic [DataW-1:0] ram_d_q, ram_d_d;
  logic [2:0]       ram_dp_q, ram_dp_d;
  logic             ram_nwe_q, ram_nwe_d;
  logic [AddrW-1:0] cnt_q, cnt_d;
  logic             sweep_q, sweep_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             lk_done_q, lk_done_d;
  logic             lk_hit_q, lk_hit_d;
  logic [DataW-1:0] lk_data_q, lk_data_d;
  logic             perr_q, perr_d;

  logic [DataW-1:0] wr_data;
  logic [2:0]       wr_par;
  logic [2:0]       rd_par;
  logic             rd_perr;
  logic             rd_hit;
  logic             load_wr;

  tlb_par3 #(
    .PAR_ODD(PAR_ODD)
  ) u_wr_par (
    .d_i(wr_data),
    .p_o(wr_par)
  );

  tlb_par3 #(
    .PAR_ODD(PAR_ODD)
  ) u_rd_par (
    .d_i(ram_q),
    .p_o(rd_par)
  );

  // Only an accepted fill writes real data; sweeps and scrubs write zeros.
  always_comb begin
    wr_data = '0;
    if (state_q == StIdle && !inv_req && fl_req) begin
      wr_data = fl_data;
    end
  end

  always_comb begin
    rd_perr = (rd_par != ram_qp);
    rd_hit  = ram_q[VALID_BIT-DLsb] && (ram_q[TAG_HI-DLsb -: TAG_W] == tag_q) && !rd_perr;
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ram_a_q   <= '0;
      ram_d_q   <= '0;
      ram_dp_q  <= '0;
      ram_nwe_q <= 1'b1;
      cnt_q     <= '0;
      sweep_q   <= 1'b0;
      tag_q     <= '0;
      lk_done_q <= 1'b0;
      lk_hit_q  <= 1'b0;
      lk_data_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ram_a_q   <= ram_a_d;
      ram_d_q   <= ram_d_d;
      ram_dp_q  <= ram_dp_d;
      ram_nwe_q <= ram_nwe_d;
      cnt_q     <= cnt_d;
      sweep_q   <= sweep_d;
      tag_q     <= tag_d;
      lk_done_q <= lk_done_d;
      lk_hit_q  <= lk_hit_d;
      lk_data_q <= lk_data_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (inv_req || fl_req) begin
          state_d = StWs;
        end else if (lk_req) begin
          state_d = StRd;
        end
      end
      StRd: begin
        state_d = StIdle;
`ifdef TLB_SCRUB_EN
        if (rd_perr) begin
          state_d = StWs;
        end
`endif
      end
      StWs:    state_d = StWp;
      StWp:    state_d = StWh;
      StWh:    state_d = sweep_q ? StSw : StIdle;
      StSw:    state_d = (cnt_q == '1) ? StIdle : StWs;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values; address and write data only move on entry to WS or RD.
  always_comb begin
    ram_a_d   = ram_a_q;
    ram_d_d   = ram_d_q;
    ram_dp_d  = ram_dp_q;
    cnt_d     = cnt_q;
    sweep_d   = sweep_q;
    tag_d     = tag_q;
    lk_done_d = 1'b0;
    lk_hit_d  = lk_hit_q;
    lk_data_d = lk_data_q;
    perr_d    = perr_q;
    load_wr   = 1'b0;
    // Strobe is a registered decode of the upcoming state, so it never glitches.
    ram_nwe_d = (state_d != StWp);

    unique case (state_q)
      StIdle: begin
        if (inv_req) begin
          load_wr = 1'b1;
          ram_a_d = '0;
          cnt_d   = '0;
          sweep_d = 1'b1;
        end else if (fl_req) begin
          load_wr = 1'b1;
          ram_a_d = fl_idx;
        end else if (lk_req) begin
          ram_a_d = lk_idx;
          tag_d   = lk_tag;
        end
      end
      StRd: begin
        lk_done_d = 1'b1;
        lk_data_d = ram_q;
        lk_hit_d  = rd_hit;
        perr_d    = rd_perr;
`ifdef TLB_SCRUB_EN
        load_wr   = rd_perr;
`endif
      end
      StSw: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q != '1) begin
          ram_a_d = cnt_q + 8'd1;
          load_wr = 1'b1;
        end else begin
          sweep_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (load_wr) begin
      ram_d_d  = wr_data;
      ram_dp_d = wr_par;
    end
  end

  // Outputs.
  always_comb begin
    busy    = (state_q != StIdle);
    ram_a   = ram_a_q;
    ram_d   = ram_d_q;
    ram_dp  = ram_dp_q;
    ram_nwe = ram_nwe_q;
    lk_done = lk_done_q;
    lk_hit  = lk_hit_q;
    lk_data = lk_data_q;
    perr    = perr_q;
  end

endmodule

// File: tb/tb_tlb_ctl.sv
// Self-checking bench for tlb_ctl: asynchronous RAM model plus an entry-level reference model.
// Expectations follow TLB_SCRUB_EN when the macro is defined for the build.
module tb_tlb_ctl;

  localparam int unsigned TAG_W   = 5;
  localparam bit          PAR_ODD = 1'b1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lk_req = 1'b0;
  logic [7:0]       lk_idx = '0;
  logic [TAG_W-1:0] lk_tag = '0;
  logic             fl_req = 1'b0;
  logic [7:0]       fl_idx = '0;
  logic [19:0]      fl_data = '0;
  logic             inv_req = 1'b0;
  logic [7:0]       ram_a;
  logic [19:0]      ram_d;
  logic [2:0]       ram_dp;
  logic             ram_nwe;
  logic [19:0]      ram_q;
  logic [2:0]       ram_qp;
  logic             busy;
  logic             lk_done;
  logic             lk_hit;
  logic [19:0]      lk_data;
  logic             perr;

  always #5 clk = ~clk;

  tlb_ctl #(
    .TAG_W  (TAG_W),
    .PAR_ODD(PAR_ODD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .lk_req (lk_req),
    .lk_idx (lk_idx),
    .lk_tag (lk_tag),
    .fl_req (fl_req),
    .fl_idx (fl_idx),
    .fl_data(fl_data),
    .inv_req(inv_req),
    .ram_a  (ram_a),
    .ram_d  (ram_d),
    .ram_dp (ram_dp),
    .ram_nwe(ram_nwe),
    .ram_q  (ram_q),
    .ram_qp (ram_qp),
    .busy   (busy),
    .lk_done(lk_done),
    .lk_hit (lk_hit),
    .lk_data(lk_data),
    .perr   (perr)
  );

  // Asynchronous-read RAM model
  logic [19:0] mem_d [256];
  logic [2:0]  mem_p [256];
  assign ram_q  = mem_d[ram_a];
  assign ram_qp = mem_p[ram_a];

  // Reference model: entry contents and which entries carry broken parity
  logic [19:0] ref_d   [256];
  bit          ref_bad [256];

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int par_bad = 0;
  int done_cnt = 0;
  logic [7:0] pulse_addr [$];

  // Parity by counting ones: bit set when needed to make the group count odd (or even).
  function automatic logic [2:0] good_par(input logic [19:0] d);
    logic [2:0] p;
    p[0] = (($countones(d[7:0])   % 2) == 0) ? PAR_ODD : !PAR_ODD;
    p[1] = (($countones(d[15:8])  % 2) == 0) ? PAR_ODD : !PAR_ODD;
    p[2] = (($countones(d[19:16]) % 2) == 0) ? PAR_ODD : !PAR_ODD;
    return p;
  endfunction

  always @(negedge clk) begin
    if (ram_nwe === 1'b0) begin
      pulses++;
      pulse_addr.push_back(ram_a);
      if (ram_dp !== good_par(ram_d)) par_bad++;
      mem_d[ram_a] = ram_d;
      mem_p[ram_a] = ram_dp;
    end
    if (lk_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy === 1'b1 && n < max) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_fill(input logic [7:0] idx, input logic [19:0] data);
    int n;
    int p0;
    @(posedge clk);
    #1;
    fl_req  = 1'b1;
    fl_idx  = idx;
    fl_data = data;
    @(posedge clk);
    #1;
    fl_req = 1'b0;
    p0 = pulses;
    wait_idle(20, n);
    chk("fill_busy", n, 3);
    chk("fill_pulses", pulses - p0, 1);
    chk("fill_addr", pulse_addr[$], idx);
    ref_d[idx]   = data;
    ref_bad[idx] = 1'b0;
  endtask

  task automatic do_lookup(input string nm, input logic [7:0] idx, input logic [TAG_W-1:0] tag);
    logic [19:0] e;
    logic        exp_hit;
    logic        exp_perr;
    int          n;
    int          exp_tail;
    e        = ref_d[idx];
    exp_perr = ref_bad[idx];
    exp_hit  = !exp_perr && e[19] && (e[18:14] == tag);
    @(posedge clk);
    #1;
    lk_req = 1'b1;
    lk_idx = idx;
    lk_tag = tag;
    @(posedge clk);
    #1;
    lk_req = 1'b0;
    chk({nm, "_busy_rd"}, busy, 1);
    chk({nm, "_done_early"}, lk_done, 0);
    @(posedge clk);
    #1;
    chk({nm, "_done"}, lk_done, 1);
    chk({nm, "_hit"}, lk_hit, exp_hit);
    chk({nm, "_perr"}, perr, exp_perr);
    chk({nm, "_data"}, lk_data, e);
    exp_tail = 0;
`ifdef TLB_SCRUB_EN
    if (exp_perr) begin
      exp_tail     = 3;
      ref_d[idx]   = '0;
      ref_bad[idx] = 1'b0;
    end
`endif
    wait_idle(20, n);
    chk({nm, "_busy_tail"}, n, exp_tail);
  endtask

  task automatic sweep_check(input string nm);
    int n;
    int p0;
    int d0;
    int q0;
    int bad;
    p0 = pulses;
    d0 = done_cnt;
    q0 = pulse_addr.size() - (pulses - p0);
    q0 = pulse_addr.size();
    wait_idle(1100, n);
    chk({nm, "_busy"}, n, 1024);
    chk({nm, "_pulses"}, pulses - p0, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (q0 + i >= pulse_addr.size()) bad++;
      else if (pulse_addr[q0+i] !== 8'(i)) bad++;
    end
    chk({nm, "_ascending"}, bad, 0);
    chk({nm, "_no_lk_done"}, done_cnt - d0, 0);
    for (int i = 0; i < 256; i++) begin
      ref_d[i]   = '0;
      ref_bad[i] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0]       r_idx;
  logic [19:0]      r_dat;
  logic [TAG_W-1:0] r_tag;
  int               p_save;
  int               d_save;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_d[i]   = '0;
      mem_p[i]   = good_par(20'h0);
      ref_d[i]   = '0;
      ref_bad[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_nwe", ram_nwe, 1);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_d", ram_d, 0);
    chk("rst_ram_dp", ram_dp, 0);
    chk("rst_lk_done", lk_done, 0);
    chk("rst_lk_hit", lk_hit, 0);
    chk("rst_lk_data", lk_data, 0);
    chk("rst_perr", perr, 0);
    rst = 1'b0;

    // Basic fill, hit, tag miss, empty-entry miss
    do_fill(8'h12, {1'b1, 5'h0A, 14'h2B5C});
    do_lookup("hit12", 8'h12, 5'h0A);
    do_lookup("tagmiss", 8'h12, 5'h0B);
    do_lookup("empty", 8'h33, 5'h00);

    // Invalidate-all after populating both ends and the middle
    do_fill(8'h00, {1'b1, 5'h03, 14'h0001});
    do_fill(8'h80, {1'b1, 5'h11, 14'h3FFF});
    do_fill(8'hFF, {1'b1, 5'h1F, 14'h2222});
    @(posedge clk);
    #1;
    inv_req = 1'b1;
    @(posedge clk);
    #1;
    inv_req = 1'b0;
    sweep_check("inv");
    do_lookup("inv00", 8'h00, 5'h03);
    do_lookup("inv80", 8'h80, 5'h11);
    do_lookup("invFF", 8'hFF, 5'h1F);

    // Parity corruption on group 1
    do_fill(8'h40, {1'b1, 5'h0A, 14'h1234});
    mem_p[8'h40][1] = ~mem_p[8'h40][1];
    ref_bad[8'h40]  = 1'b1;
    p_save = pulses;
    do_lookup("perr40", 8'h40, 5'h0A);
`ifdef TLB_SCRUB_EN
    chk("scrub_pulses", pulses - p_save, 1);
    chk("scrub_addr", pulse_addr[$], 8'h40);
`else
    chk("noscrub_pulses", pulses - p_save, 0);
`endif
    do_lookup("relk40", 8'h40, 5'h0A);

    // Randomized fills and lookups over a small index set so hits recur
    for (int k = 0; k < 60; k++) begin
      r_idx = 8'(($urandom_range(0, 7) * 32) + 5);
      if ($urandom_range(0, 1) == 1) begin
        r_dat = 20'($urandom);
        if ($urandom_range(0, 3) != 0) r_dat[19] = 1'b1;
        do_fill(r_idx, r_dat);
      end else begin
        r_dat = ref_d[r_idx];
        r_tag = ($urandom_range(0, 1) == 1) ? r_dat[18:14] : TAG_W'($urandom);
        do_lookup("rnd", r_idx, r_tag);
      end
    end

    // All three requesters at once: sweep wins, others are dropped
    @(posedge clk);
    #1;
    inv_req = 1'b1;
    fl_req  = 1'b1;
    fl_idx  = 8'h55;
    fl_data = {1'b1, 5'h07, 14'h0ABC};
    lk_req  = 1'b1;
    lk_idx  = 8'h12;
    lk_tag  = 5'h0A;
    @(posedge clk);
    #1;
    inv_req = 1'b0;
    fl_req  = 1'b0;
    lk_req  = 1'b0;
    d_save  = done_cnt;
    sweep_check("arb");
    p_save = pulses;
    repeat (8) @(posedge clk);
    #1;
    chk("arb_no_extra_pulse", pulses - p_save, 0);
    chk("arb_no_lk_done", done_cnt - d_save, 0);
    do_lookup("arb55", 8'h55, 5'h07);

    // Reset in the middle of a sweep
    @(posedge clk);
    #1;
    inv_req = 1'b1;
    @(posedge clk);
    #1;
    inv_req = 1'b0;
    repeat (299) @(posedge clk);
    #1;
    chk("midsweep_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_nwe", ram_nwe, 1);
    chk("rstmid_lk_done", lk_done, 0);
    p_save = pulses;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_quiet", pulses - p_save, 0);
    do_fill(8'h21, {1'b1, 5'h15, 14'h0F0F});
    do_lookup("post21", 8'h21, 5'h15);
    do_lookup("post90", 8'h90, 5'h00);

    chk("write_parity", par_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
